fifo_uart_tx: RTL

Read-side consumer for the team's FIFO: drains `bitWidth`-bit words from a FIFO's pop interface and transmits each word as consecutive 8N1 UART bytes, least-significant byte first. Sits between a FIFO instance and the board TX pin; the pop handshake matches the FIFO's head-visible read port (`popData` shows the head word, `pop` advances it at the next edge).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/fifo_uart_tx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides.
// Contents: FSM state encoding, line levels, bits per byte, and a helper
// that gives the width of an index/counter for a given range (minimum 1).
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic        START_LEVEL   = 1'b0;
  localparam logic        STOP_LEVEL    = 1'b1;
  localparam logic        IDLE_LEVEL    = 1'b1;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: counts 0..clocksPerBit-1 and wraps.
// Ports:
//   i_clock      - clock, rising edge
//   i_reset      - asynchronous active-low reset
//   i_clear      - synchronous clear; holds the count at zero while high
//   o_bit_done   - one-cycle pulse in the last cycle of each bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned clocksPerBit = 434
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_bit_done
);

  localparam int unsigned     CntW   = idx_width(clocksPerBit);
  localparam logic [CntW-1:0] CntMax = CntW'(clocksPerBit - 1);

  logic [CntW-1:0] r_count;
  logic            w_wrap;

  assign w_wrap     = (r_count == CntMax);
  assign o_bit_done = w_wrap && !i_clear;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops bitWidth-bit words from a head-visible
// FIFO read port and sends each as bitWidth/8 consecutive 8N1 bytes, LSB byte
// first, with no gap between bytes of a word.
// Ports:
//   i_clock          - clock, rising edge
//   i_reset          - asynchronous active-low reset
//   i_tx_enable      - permits starting a new word (sampled only when idle)
//   i_fifo_empty     - FIFO empty flag
//   i_fifo_pop_data  - FIFO head word
//   o_fifo_pop       - one-cycle pop pulse to the FIFO
//   o_txd            - registered serial line, idle high
//   o_busy           - high while a word is being serialized
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned bitWidth     = 32,
  parameter int unsigned clocksPerBit = 434
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_tx_enable,
  input  logic                i_fifo_empty,
  input  logic [bitWidth-1:0] i_fifo_pop_data,
  output logic                o_fifo_pop,
  output logic                o_txd,
  output logic                o_busy
);

  localparam int unsigned         BytesPerWord = bitWidth / BITS_PER_BYTE;
  localparam int unsigned         ByteIdxW     = idx_width(BytesPerWord);
  localparam logic [ByteIdxW-1:0] LastByte     = ByteIdxW'(BytesPerWord - 1);
  localparam logic [2:0]          LastBit      = 3'(BITS_PER_BYTE - 1);

  uart_state_e               r_state, w_state_next;
  logic [bitWidth-1:0]       r_word, w_word_next;
  logic [2:0]                r_bit_idx, w_bit_idx_next;
  logic [ByteIdxW-1:0]       r_byte_idx, w_byte_idx_next;
  logic                      r_txd, w_txd_next;

  logic                      w_bit_done;
  logic                      w_baud_clear;
  logic [BITS_PER_BYTE-1:0]  w_cur_byte;
  logic [2:0]                w_bit_idx_inc;

  // Including i_reset keeps the pop low while reset is asserted, even though
  // the registered state alone would already read idle.
  assign o_fifo_pop = (r_state == StIdle) && !i_fifo_empty && i_tx_enable && i_reset;
  assign o_busy     = (r_state != StIdle);
  assign o_txd      = r_txd;

  assign w_cur_byte    = r_word[BITS_PER_BYTE-1:0];
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // Holding the divider clear while idle aligns it to the start-bit entry;
  // every later bit is exactly one wrap long, so it stays aligned without
  // further clears.
  assign w_baud_clear = (r_state == StIdle);

  uart_baud_tick #(
    .clocksPerBit (clocksPerBit)
  ) u_baud_tick (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_baud_clear),
    .o_bit_done (w_bit_done)
  );

  always_comb begin
    w_state_next    = r_state;
    w_word_next     = r_word;
    w_bit_idx_next  = r_bit_idx;
    w_byte_idx_next = r_byte_idx;
    w_txd_next      = r_txd;

    case (r_state)
      StIdle: begin
        w_txd_next = IDLE_LEVEL;
        if (o_fifo_pop) begin
          w_state_next    = StStart;
          w_word_next     = i_fifo_pop_data;
          w_byte_idx_next = '0;
          w_txd_next      = START_LEVEL;
        end
      end
      StStart: begin
        if (w_bit_done) begin
          w_state_next   = StData;
          w_bit_idx_next = 3'd0;
          w_txd_next     = w_cur_byte[0];
        end
      end
      StData: begin
        if (w_bit_done) begin
          if (r_bit_idx == LastBit) begin
            w_state_next = StStop;
            w_txd_next   = STOP_LEVEL;
          end else begin
            w_bit_idx_next = w_bit_idx_inc;
            w_txd_next     = w_cur_byte[w_bit_idx_inc];
          end
        end
      end
      StStop: begin
        if (w_bit_done) begin
          if (r_byte_idx != LastByte) begin
            w_state_next    = StStart;
            w_byte_idx_next = r_byte_idx + 1'b1;
            w_word_next     = r_word >> BITS_PER_BYTE;
            w_txd_next      = START_LEVEL;
          end else begin
            w_state_next = StIdle;
            w_txd_next   = IDLE_LEVEL;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_txd_next   = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_word     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_txd      <= IDLE_LEVEL;
    end else begin
      r_state    <= w_state_next;
      r_word     <= w_word_next;
      r_bit_idx  <= w_bit_idx_next;
      r_byte_idx <= w_byte_idx_next;
      r_txd      <= w_txd_next;
    end
  end

endmodule
